// File: rtl/gpu_vga_scanout_if.sv
// Video-memory read port 1 plus VGA pin bundle for the scanout block.
// mem_rden1/mem_addr1 form a request with no backpressure; mem_dout1 answers it exactly one cycle later.
interface gpu_vga_scanout_if;
  logic        mem_rden1;
  logic [14:0] mem_addr1;
  logic [11:0] mem_dout1;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vblank;
  logic        frame_start;

  modport master (
    output mem_rden1, mem_addr1,
    input  mem_dout1,
    output vga_hs, vga_vs, vga_r, vga_g, vga_b, vblank, frame_start
  );

  modport slave (
    input  mem_rden1, mem_addr1,
    output mem_dout1,
    input  vga_hs, vga_vs, vga_r, vga_g, vga_b, vblank, frame_start
  );
endinterface

// File: rtl/gpu_vga_scanout.sv
// VGA scanout: timing counters (S0), memory-latency alignment (S1), output registers (S2).
// Framebuffer pixels are upscaled 4x4 using a row-base register instead of a multiplier.
module gpu_vga_scanout #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_VIS  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int FB_W   = 200,
  parameter int FB_H   = 150
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  gpu_vga_scanout_if.master bus
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
  localparam logic [10:0] HS_FIRST = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0]  VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [14:0] FB_W_C   = 15'(FB_W);

  if (FB_W * 4 != H_VIS || FB_H * 4 != V_VIS) begin : g_bad_geometry
    $error("gpu_vga_scanout: framebuffer must be exactly one quarter of the visible area");
  end

  // S0 state
  logic        run;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [14:0] row_base;

  // S0 combinational terms
  logic        h_wrap;
  logic        v_wrap;
  logic        vis_raw;
  logic        hs_raw;
  logic        vs_raw;
  logic        vblank_raw;
  logic        frame_raw;

  // S1 alignment registers
  logic        vis_d;
  logic        hs_d;
  logic        vs_d;
  logic        vblank_d;
  logic        frame_d;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // run is en delayed by one cycle, so the first counted cycle after en rises is (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      hcnt     <= '0;
      vcnt     <= '0;
      row_base <= '0;
    end else begin
      run <= en;
      if (!en) begin
        hcnt     <= '0;
        vcnt     <= '0;
        row_base <= '0;
      end else if (run) begin
        if (h_wrap) begin
          hcnt <= '0;
          if (v_wrap) begin
            vcnt     <= '0;
            row_base <= '0;
          end else begin
            vcnt <= vcnt + 10'd1;
            if (vcnt[1:0] == 2'd3 && vcnt < V_VIS_C) begin
              row_base <= row_base + FB_W_C;
            end
          end
        end else begin
          hcnt <= hcnt + 11'd1;
        end
      end
    end
  end

  always_comb begin
    vis_raw    = run && (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    hs_raw     = run && (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    vs_raw     = run && (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    vblank_raw = run && (vcnt >= V_VIS_C);
    frame_raw  = run && (hcnt == 11'd0) && (vcnt == 10'd0);
  end

  assign bus.mem_rden1 = vis_raw;
  assign bus.mem_addr1 = vis_raw ? (row_base + {6'd0, hcnt[10:2]}) : 15'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_d    <= 1'b0;
      hs_d     <= 1'b0;
      vs_d     <= 1'b0;
      vblank_d <= 1'b0;
      frame_d  <= 1'b0;
    end else begin
      vis_d    <= vis_raw;
      hs_d     <= hs_raw;
      vs_d     <= vs_raw;
      vblank_d <= vblank_raw;
      frame_d  <= frame_raw;
    end
  end

  // Memory data is only trusted when the matching request was a visible pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vga_r       <= 4'd0;
      bus.vga_g       <= 4'd0;
      bus.vga_b       <= 4'd0;
      bus.vga_hs      <= ~HS_POL;
      bus.vga_vs      <= ~VS_POL;
      bus.vblank      <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.vga_r       <= vis_d ? bus.mem_dout1[11:8] : 4'd0;
      bus.vga_g       <= vis_d ? bus.mem_dout1[7:4]  : 4'd0;
      bus.vga_b       <= vis_d ? bus.mem_dout1[3:0]  : 4'd0;
      bus.vga_hs      <= hs_d ? HS_POL : ~HS_POL;
      bus.vga_vs      <= vs_d ? VS_POL : ~VS_POL;
      bus.vblank      <= vblank_d;
      bus.frame_start <= frame_d;
    end
  end

endmodule

// File: tb/tb_gpu_vga_scanout.sv
// Bench for gpu_vga_scanout: a full-size 800x600 instance and a scaled-down instance
// share clock, reset and enable; both are compared every cycle against a position-based model.
module tb_gpu_vga_scanout;

  // scaled-down geometry so whole frames fit in a short run
  localparam int S_HV = 16, S_HFP = 2, S_HSY = 4, S_HBP = 2;
  localparam int S_VV = 12, S_VFP = 1, S_VSY = 2, S_VBP = 3;
  localparam int S_FBW = 4, S_FBH = 3;

  int hv[2]   = '{800, S_HV};
  int hfp[2]  = '{40, S_HFP};
  int hsy[2]  = '{128, S_HSY};
  int htot[2] = '{1056, S_HV + S_HFP + S_HSY + S_HBP};
  int vv[2]   = '{600, S_VV};
  int vfp[2]  = '{1, S_VFP};
  int vsy[2]  = '{4, S_VSY};
  int vtot[2] = '{628, S_VV + S_VFP + S_VSY + S_VBP};
  int fbw[2]  = '{200, S_FBW};

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] mem [0:32767];

  gpu_vga_scanout_if bus_f ();
  gpu_vga_scanout_if bus_s ();

  gpu_vga_scanout dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus_f)
  );

  gpu_vga_scanout #(
    .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
    .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .FB_W(S_FBW), .FB_H(S_FBH)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // BRAM-style synchronous read; garbage when not requested so leaks show up on the pins
  always @(posedge clk) begin
    bus_f.mem_dout1 <= bus_f.mem_rden1 ? mem[bus_f.mem_addr1] : 12'($urandom);
    bus_s.mem_dout1 <= bus_s.mem_rden1 ? mem[bus_s.mem_addr1] : 12'($urandom);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pos = counted cycles since the scan (re)started, -1 while idle.
  int pos[2] = '{-1, -1};
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] pins_e[2];
  int max_addr_s = 0;

  function automatic int next_pos(int k, int p, logic en_now);
    if (!en_now) return -1;
    if (p < 0) return 0;
    return (p + 1) % (htot[k] * vtot[k]);
  endfunction

  function automatic logic [15:0] exp_req(int k, int p);
    int h, v;
    if (p < 0) return 16'h0;
    h = p % htot[k];
    v = p / htot[k];
    if (h < hv[k] && v < vv[k]) return {1'b1, 15'((v / 4) * fbw[k] + h / 4)};
    return 16'h0;
  endfunction

  // {rgb, hs, vs, vblank, frame_start}; both sync polarities are active-high
  function automatic logic [15:0] exp_pins(int k, int p);
    int h, v;
    logic [11:0] rgb;
    logic hs, vs, vb, fr;
    if (p < 0) return 16'h0;
    h = p % htot[k];
    v = p / htot[k];
    rgb = (h < hv[k] && v < vv[k]) ? mem[(v / 4) * fbw[k] + h / 4] : 12'h0;
    hs = (h >= hv[k] + hfp[k]) && (h < hv[k] + hfp[k] + hsy[k]);
    vs = (v >= vv[k] + vfp[k]) && (v < vv[k] + vfp[k] + vsy[k]);
    vb = (v >= vv[k]);
    fr = (p == 0);
    return {rgb, hs, vs, vb, fr};
  endfunction

  function automatic logic [15:0] obs_req(int k);
    if (k == 0) return {bus_f.mem_rden1, bus_f.mem_addr1};
    return {bus_s.mem_rden1, bus_s.mem_addr1};
  endfunction

  function automatic logic [15:0] obs_pins(int k);
    if (k == 0)
      return {bus_f.vga_r, bus_f.vga_g, bus_f.vga_b, bus_f.vga_hs, bus_f.vga_vs,
              bus_f.vblank, bus_f.frame_start};
    return {bus_s.vga_r, bus_s.vga_g, bus_s.vga_b, bus_s.vga_hs, bus_s.vga_vs,
            bus_s.vblank, bus_s.frame_start};
  endfunction

  task automatic reset_model();
    pos[0] = -1;
    pos[1] = -1;
    exp_q0 = '{16'h0, 16'h0};
    exp_q1 = '{16'h0, 16'h0};
    pins_e[0] = 16'h0;
    pins_e[1] = 16'h0;
  endtask

  // ---------------- scoreboard: advance at each edge, compare mid-cycle ----------------
  initial begin
    reset_model();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        reset_model();
      end else begin
        for (int k = 0; k < 2; k++) pos[k] = next_pos(k, pos[k], en);
        exp_q0.push_back(exp_pins(0, pos[0]));
        exp_q1.push_back(exp_pins(1, pos[1]));
        pins_e[0] = exp_q0.pop_front();
        pins_e[1] = exp_q1.pop_front();
      end
      #5;
      if (!rst_n) reset_model();
      check("req_full",  32'(obs_req(0)),  32'(exp_req(0, pos[0])));
      check("pins_full", 32'(obs_pins(0)), 32'(pins_e[0]));
      check("req_small",  32'(obs_req(1)),  32'(exp_req(1, pos[1])));
      check("pins_small", 32'(obs_pins(1)), 32'(pins_e[1]));
      if (bus_s.mem_rden1 && int'(bus_s.mem_addr1) > max_addr_s) max_addr_s = int'(bus_s.mem_addr1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pos(input int k, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (pos[k] == target) return;
    end
    check("wait_pos_timeout", 32'(pos[k]), 32'(target));
  endtask

  task automatic wait_frame_s(input int budget, output int waited, output bit found);
    found = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      waited++;
      if (bus_s.frame_start) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("async_rst_req_full",  32'(obs_req(0)),  32'h0);
    check("async_rst_pins_full", 32'(obs_pins(0)), 32'h0);
    check("async_rst_pins_small", 32'(obs_pins(1)), 32'h0);
    cycles(n);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    bit found;
    rst_n = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 32768; i++) mem[i] = 12'($urandom);

    // reset held with EN high, then release into the first line
    cycles(5);
    check("reset_hs_low", 32'(bus_f.vga_hs), 32'h0);
    check("reset_vs_low", 32'(bus_f.vga_vs), 32'h0);
    rst_n = 1'b1;

    // drop EN mid-line at (300,10) on the full-size instance
    wait_pos(0, 10 * 1056 + 300, 12000);
    en = 1'b0;
    cycles(1);
    check("en_drop_rden", 32'(bus_f.mem_rden1), 32'h0);
    cycles(20);
    en = 1'b1;
    cycles(3000);

    // async reset in the middle of a small-instance frame
    wait_pos(1, 6 * htot[1] + 5, 1000);
    pulse_reset(3);
    cycles(200);

    // randomized enable drops, resets and free-running stretches
    repeat (12) begin
      cycles($urandom_range(20, 1500));
      case ($urandom_range(0, 2))
        0: begin
          en = 1'b0;
          cycles($urandom_range(1, 8));
          en = 1'b1;
        end
        1: pulse_reset($urandom_range(1, 4));
        default: ;
      endcase
    end

    // uninterrupted stretch: frame period and full address range of the small instance
    wait_frame_s(1000, waited, found);
    check("frame_found_first", 32'(found), 32'h1);
    wait_frame_s(1000, waited, found);
    check("frame_found_second", 32'(found), 32'h1);
    check("frame_period_small", 32'(waited), 32'(htot[1] * vtot[1]));
    check("addr_max_small", 32'(max_addr_s), 32'(S_FBW * S_FBH - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
